serial_code_converter: RTL and testbench

Parametrised Mealy serial code converter, the generalised successor to the fixed 4-bit BCD-to-excess-3 serial machine. It adds (encode) or subtracts (decode) a constant `K` to/from LSB-first serial words of `WIDTH` bits. The output bit is produced in the same cycle as the input bit. It sits between a serial bit source and a serial sink, and adds a valid qualifier, per-word mode selection and a word-boundary strobe.

---
 rtl/serial_code_converter_if.sv | 22 ++
 rtl/serial_code_converter.sv | 105 ++++++++++
 tb/tb_serial_code_converter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_code_converter_if.sv
// Serial bit-stream bundle between a bit source (master) and the code
// converter (slave).
//   x, x_valid, mode     : source -> converter, one bit per valid cycle, LSB first
//   y, y_valid, word_done: converter -> sink, same cycle as the input bit
//   ovf                  : converter -> sink, only when SERIAL_CODE_CONVERTER_OVF_EN
interface serial_code_converter_if;
  logic x;
  logic x_valid;
  logic mode;
  logic y;
  logic y_valid;
  logic word_done;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
  logic ovf;

  modport master (output x, x_valid, mode, input y, y_valid, word_done, ovf);
  modport slave  (input x, x_valid, mode, output y, y_valid, word_done, ovf);
`else
  modport master (output x, x_valid, mode, input y, y_valid, word_done);
  modport slave  (input x, x_valid, mode, output y, y_valid, word_done);
`endif
endinterface

// File: rtl/serial_code_converter.sv
// Mealy serial code converter: adds (mode=0) or subtracts (mode=1) the
// constant K to/from LSB-first serial words of WIDTH bits. The output bit is
// combinational from the current input bit and the registered carry/borrow.
// Optional feature macro: SERIAL_CODE_CONVERTER_OVF_EN adds the registered
// carry/borrow-out of the last completed word on bus.ovf.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; wins over a coincident valid bit
//   bus   - serial_code_converter_if.slave (x/x_valid/mode in,
//           y/y_valid/word_done[/ovf] out)
module serial_code_converter #(
  parameter int WIDTH = 4,
  parameter int K     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_code_converter_if.slave   bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] KV     = WIDTH'(K);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {FIRST, RUN, LAST} phase_t;

  logic [CW-1:0] cnt, cnt_nxt;
  logic          c, c_nxt;
  logic          mode_q, mode_q_nxt;
  phase_t        phase;
  logic          fire, eff_mode, k, ci, cout;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
  logic          ovf_q, ovf_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      c      <= 1'b0;
      mode_q <= 1'b0;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      cnt    <= cnt_nxt;
      c      <= c_nxt;
      mode_q <= mode_q_nxt;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
      ovf_q  <= ovf_nxt;
`endif
    end
  end

  always_comb begin
    // phase is a decode of the bit index, not separate state
    phase = RUN;
    if (cnt == '0)            phase = FIRST;
    else if (cnt == LAST_IDX) phase = LAST;

    fire     = bus.x_valid & ~reset;
    // bit 0 takes mode straight from the pin so a word needs no setup cycle
    eff_mode = (phase == FIRST) ? bus.mode : mode_q;
    ci       = (phase == FIRST) ? 1'b0 : c;
    k        = KV[cnt];
    cout     = eff_mode ? ((~bus.x & k) | (~(bus.x ^ k) & ci))
                        : ((bus.x & k) | (bus.x & ci) | (k & ci));

    cnt_nxt    = cnt;
    c_nxt      = c;
    mode_q_nxt = mode_q;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
    ovf_nxt    = ovf_q;
`endif

    if (fire) begin
      case (phase)
        FIRST: begin
          mode_q_nxt = bus.mode;
          cnt_nxt    = cnt + CW'(1);
          c_nxt      = cout;
        end
        LAST: begin
          // carry never crosses into the next word
          cnt_nxt = '0;
          c_nxt   = 1'b0;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
          ovf_nxt = cout;
`endif
        end
        default: begin
          cnt_nxt = cnt + CW'(1);
          c_nxt   = cout;
        end
      endcase
    end

    bus.y         = fire & (bus.x ^ k ^ ci);
    bus.y_valid   = fire;
    bus.word_done = fire & (phase == LAST);
  end

`ifdef SERIAL_CODE_CONVERTER_OVF_EN
  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_code_converter.sv
module tb_serial_code_converter;

  typedef struct packed {
    logic y;
    logic wd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$], qb[$];
  bit   oqa[$], oqb[$];
  bit   pend_a = 0, pend_b = 0, rst_prev = 0;

  serial_code_converter_if ifa ();
  serial_code_converter_if ifb ();

  serial_code_converter #(.WIDTH(4), .K(3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  serial_code_converter #(.WIDTH(8), .K('h5A)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int sel, input logic xv, input logic yv, input logic yb,
                     input logic wd, input logic ov, input logic rst, input logic rp);
    exp_t  e;
    bit    eo;
    bit    pd;
    string n;
    n  = sel ? "b" : "a";
    pd = sel ? pend_b : pend_a;
    if (pd) begin
      if (sel) pend_b = 0; else pend_a = 0;
      if ((sel ? oqb.size() : oqa.size()) == 0) chk({n, "_ovf_queue"}, 0, 1);
      else begin
        eo = sel ? oqb.pop_front() : oqa.pop_front();
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
        chk({n, "_ovf"}, int'(ov), int'(eo));
`endif
      end
    end
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
    if (rp) chk({n, "_ovf_after_reset"}, int'(ov), 0);
`endif
    chk({n, "_y_valid"}, int'(yv), int'(xv & ~rst));
    if (yv) begin
      if ((sel ? qb.size() : qa.size()) == 0) chk({n, "_unexpected_bit"}, 1, 0);
      else begin
        e = sel ? qb.pop_front() : qa.pop_front();
        chk({n, "_y"}, int'(yb), int'(e.y));
        chk({n, "_word_done"}, int'(wd), int'(e.wd));
        if (wd) begin
          if (sel) pend_b = 1; else pend_a = 1;
        end
      end
    end else begin
      chk({n, "_idle_y_wd"}, int'({yb, wd}), 0);
    end
  endtask

  always @(negedge clk) begin
    logic ova, ovb;
`ifdef SERIAL_CODE_CONVERTER_OVF_EN
    ova = ifa.ovf;
    ovb = ifb.ovf;
`else
    ova = 1'b0;
    ovb = 1'b0;
`endif
    mon(0, ifa.x_valid, ifa.y_valid, ifa.y, ifa.word_done, ova, reset, rst_prev);
    mon(1, ifb.x_valid, ifb.y_valid, ifb.y, ifb.word_done, ovb, reset, rst_prev);
    rst_prev = reset;
    if (done) begin
      chk("leftover_expected_bits", qa.size() + qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_bit(input int sel, input bit xb, input bit v, input bit md);
    if (sel == 0) begin
      ifa.x = xb; ifa.x_valid = v; ifa.mode = md;
    end else begin
      ifb.x = xb; ifb.x_valid = v; ifb.mode = md;
    end
    @(posedge clk);
    #1;
    if (sel == 0) ifa.x_valid = 1'b0; else ifb.x_valid = 1'b0;
  endtask

  // Reference: whole-word integer add/subtract, then split into LSB-first bits.
  task automatic send_word(input int sel, input int val, input bit md,
                           input int maxgap, input bit tog);
    int   w, kc, m, r;
    bit   o, mb;
    exp_t e;
    w  = sel ? 8 : 4;
    kc = sel ? 'h5A : 3;
    m  = 1 << w;
    if (md) begin
      r = val - kc;
      o = (r < 0);
      if (o) r += m;
    end else begin
      r = val + kc;
      o = (r >= m);
      if (o) r -= m;
    end
    if (sel) oqb.push_back(o); else oqa.push_back(o);
    for (int i = 0; i < w; i++) begin
      repeat ($urandom_range(0, maxgap))
        drive_bit(sel, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      e.y  = 1'((r >> i) & 1);
      e.wd = (i == w - 1);
      if (sel) qb.push_back(e); else qa.push_back(e);
      mb = (i == 0 || !tog) ? md : 1'($urandom_range(0, 1));
      drive_bit(sel, 1'((val >> i) & 1), 1'b1, mb);
    end
  endtask

  initial begin
    ifa.x = 1'b1; ifa.x_valid = 1'b1; ifa.mode = 1'b0;  // dropped: reset wins
    ifb.x = 1'b0; ifb.x_valid = 1'b0; ifb.mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ifa.x_valid = 1'b0;
    drive_bit(0, 0, 0, 0);

    send_word(0, 5, 0, 0, 0);    // -> 8
    send_word(0, 12, 1, 0, 0);   // -> 9
    send_word(0, 13, 0, 0, 0);   // -> 0, carry out
    send_word(0, 2, 1, 0, 0);    // -> 15, borrow out
    send_word(0, 5, 0, 3, 1);    // bubbles + mode toggling -> 8
    send_word(0, 9, 0, 0, 0);    // back-to-back -> 12

    // two bits of encode 13 (sum 16 -> low bits 0,0), then reset mid-word
    qa.push_back('{y: 1'b0, wd: 1'b0});
    qa.push_back('{y: 1'b0, wd: 1'b0});
    drive_bit(0, 1, 1, 0);
    drive_bit(0, 0, 1, 0);
    reset = 1'b1;
    drive_bit(0, 1, 1, 1);
    reset = 1'b0;
    send_word(0, 0, 0, 0, 0);    // fresh word -> 3

    for (int n = 0; n < 40; n++)
      send_word(0, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 2, 1);

    for (int v = 0; v < 256; v++)
      for (int md = 0; md < 2; md++)
        send_word(1, v, 1'(md), 1, 1);

    repeat (3) drive_bit(0, 0, 0, 0);
    done = 1'b1;
  end

endmodule
